// File: rtl/serial_pkg.sv
// Shared types and constants for the framed serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Counter width that still holds n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Counts clk cycles within one serial bit; tick marks the last cycle of the bit.
module bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = clog2_min1(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LastCnt);

    // Wrapping on tick restarts the count at every bit boundary and state change.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx_frame.sv
// Parallel-in, serial-out framed transmitter: start bit, LSB-first data,
// optional even parity, stop bit. The line idles high.
module serial_tx_frame
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IdxW = clog2_min1(DATA_W);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic              ser_q, ser_d;
    logic              done_q, done_d;
    logic              parity_q, parity_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              bit_tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == StIdle),
        .tick (bit_tick)
    );

    // ser_d carries the level of the state being entered, so the line is registered.
    always_comb begin
        state_d  = state_q;
        ser_d    = ser_q;
        done_d   = 1'b0;
        parity_d = parity_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        unique case (state_q)
            StIdle: begin
                ser_d = IDLE_LEVEL;
                if (load_valid) begin
                    shift_d  = load_data;
                    parity_d = ^load_data;
                    idx_d    = '0;
                    state_d  = StStart;
                    ser_d    = START_LEVEL;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                    ser_d   = shift_q[0];
                end
            end
            StData: begin
                if (bit_tick) begin
                    if (idx_q == LastIdx) begin
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                            ser_d   = parity_q;
                        end else begin
                            state_d = StStop;
                            ser_d   = IDLE_LEVEL;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IdxW'(1);
                        ser_d   = shift_d[0];
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    state_d = StStop;
                    ser_d   = IDLE_LEVEL;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    state_d = StIdle;
                    ser_d   = IDLE_LEVEL;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                ser_d   = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ser_q    <= IDLE_LEVEL;
            done_q   <= 1'b0;
            parity_q <= 1'b0;
            shift_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ser_q    <= ser_d;
            done_q   <= done_d;
            parity_q <= parity_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
        end
    end

    assign load_ready = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign ser_out    = ser_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Randomized bench for serial_tx_frame: two configurations checked against a
// bit-list model of the frame built from the word.
module tb_serial_tx_frame;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid [2];
    logic [DW-1:0] data  [2];
    logic          ready [2];
    logic          ser   [2];
    logic          busy  [2];
    logic          done  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_tx_frame #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(4),
        .PARITY_EN   (0)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .load_valid(valid[0]),
        .load_data (data[0]),
        .load_ready(ready[0]),
        .ser_out   (ser[0]),
        .busy      (busy[0]),
        .done      (done[0])
    );

    serial_tx_frame #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(1),
        .PARITY_EN   (1)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .load_valid(valid[1]),
        .load_data (data[1]),
        .load_ready(ready[1]),
        .ser_out   (ser[1]),
        .busy      (busy[1]),
        .done      (done[1])
    );

    function automatic int cpb(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int par_en(input int u);
        return (u == 0) ? 0 : 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int u, input string tag);
        check_eq($sformatf("%s u%0d ser", tag, u), ser[u], 1);
        check_eq($sformatf("%s u%0d ready", tag, u), ready[u], 1);
        check_eq($sformatf("%s u%0d busy", tag, u), busy[u], 0);
        check_eq($sformatf("%s u%0d done", tag, u), done[u], 0);
    endtask

    // Call between a negedge and the next posedge; returns at the negedge of the done cycle.
    task automatic run_frame(input int u, input logic [DW-1:0] word, input bit hold,
                             input logic [DW-1:0] next_word, input int inject_at);
        bit exp_bits[$];
        int ones = 0;
        int c = cpb(u);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            exp_bits.push_back(word[i]);
            ones += int'(word[i]);
        end
        if (par_en(u) != 0) exp_bits.push_back(ones % 2 == 1);
        exp_bits.push_back(1'b1);

        valid[u] = 1'b1;
        data[u]  = word;
        check_eq($sformatf("u%0d ready before accept", u), ready[u], 1);
        @(posedge clk);
        #1;
        if (hold) begin
            data[u] = next_word;
        end else begin
            valid[u] = 1'b0;
            data[u]  = DW'($urandom);
        end
        for (int k = 0; k < exp_bits.size() * c; k++) begin
            @(negedge clk);
            if (k == inject_at) begin
                valid[u] = 1'b1;
                data[u]  = 8'h3C;
            end else if (inject_at >= 0 && k == inject_at + 1) begin
                valid[u] = 1'b0;
            end
            check_eq($sformatf("u%0d w%02h ser k%0d", u, word, k), ser[u], exp_bits[k / c]);
            check_eq($sformatf("u%0d w%02h busy k%0d", u, word, k), busy[u], 1);
            check_eq($sformatf("u%0d w%02h ready k%0d", u, word, k), ready[u], 0);
            check_eq($sformatf("u%0d w%02h early done k%0d", u, word, k), done[u], 0);
        end
        @(negedge clk);
        check_eq($sformatf("u%0d w%02h done pulse", u, word), done[u], 1);
        check_eq($sformatf("u%0d w%02h busy at done", u, word), busy[u], 0);
        check_eq($sformatf("u%0d w%02h ser at done", u, word), ser[u], 1);
        check_eq($sformatf("u%0d w%02h ready at done", u, word), ready[u], 1);
    endtask

    initial begin
        logic [DW-1:0] w, w2;
        int u;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            data[i]  = '0;
        end
        #2;
        check_idle(0, "reset");
        check_idle(1, "reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "post reset");
        check_idle(1, "post reset");

        // Basic and parity frames.
        run_frame(0, 8'hA5, 1'b0, 8'h00, -1);
        @(negedge clk);
        check_idle(0, "after A5");
        run_frame(1, 8'hA5, 1'b0, 8'h00, -1);
        @(negedge clk);
        run_frame(1, 8'h07, 1'b0, 8'h00, -1);
        @(negedge clk);

        // Back-to-back with valid held: one idle-high cycle between frames.
        run_frame(1, 8'h00, 1'b1, 8'hFF, -1);
        run_frame(1, 8'hFF, 1'b0, 8'h00, -1);
        @(negedge clk);
        check_idle(1, "after b2b");

        // Load attempt while busy must be ignored.
        run_frame(0, 8'h96, 1'b0, 8'h00, 13);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_idle(0, "no second frame");
        end

        // Reset during data bit 3 of 0xA5 (bit value 0).
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("mid-frame ser before reset", ser[0], 0);
        check_eq("mid-frame busy before reset", busy[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle(0, "async reset mid-frame");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_idle(0, "abandoned frame");
        end
        run_frame(0, 8'h5A, 1'b0, 8'h00, -1);
        @(negedge clk);

        // Randomized traffic on both configurations.
        repeat (24) begin
            u  = int'($urandom_range(0, 1));
            w  = DW'($urandom);
            w2 = DW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                run_frame(u, w, 1'b1, w2, -1);
                run_frame(u, w2, 1'b0, 8'h00, -1);
            end else begin
                run_frame(u, w, 1'b0, 8'h00, -1);
            end
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check_idle(u, "random gap");
                check_idle(1 - u, "other idle");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
